kamus_mem_stage: RTL

Memory-access stage of the kamus core, directly downstream of the execute stage, and owner of the EX/MEM→MEM/WB pipeline register. It takes the execute result (address or ALU value), store data and buffered control signals and performs the L1D access over a request/grant/response handshake. It aligns store data, extracts and extends load data, stalls upstream stages while an access is outstanding, and registers everything for write-back.

---
 rtl/kamus_mem_stage_if.sv | 13 +
 rtl/kamus_mem_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/kamus_mem_stage_if.sv
// kamus_mem_stage_if: L1D request/grant/response bus between the MEM stage and the data cache
interface kamus_mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/kamus_mem_stage.sv
// kamus_mem_stage: L1D access stage and MEM/WB register; optional KAMUS_MISALIGN_TRAP_EN traps misaligned accesses
package kamus_pkg;
  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW
  } operation_e;
  typedef enum logic [1:0] {SEL_PC4, SEL_BRANCH, SEL_JALR, SEL_TRAP} instr_addr_sel_state_e;
endpackage

module kamus_mem_stage
  import kamus_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  operation_e            operation_i,
  input  logic [31:0]           ex_i,
  input  logic [31:0]           rs2_data_i,
  input  logic [4:0]            rd_addr_i,
  input  logic [31:0]           next_pc_i,
  input  logic                  is_branch_taken_i,
  input  instr_addr_sel_state_e instr_addr_sel_i,
  input  logic [1:0]            wb_mux_sel_i,
  input  logic                  l1d_wr_en_i,
  input  logic                  regfile_wr_en_i,
  output logic                  stall_o,
  kamus_mem_stage_if.master     dmem,
  output logic                  valid_o,
  output logic [31:0]           ex_o,
  output logic [31:0]           mem_data_o,
  output logic [4:0]            rd_addr_o,
  output logic [31:0]           next_pc_o,
  output logic                  is_branch_taken_o,
  output instr_addr_sel_state_e instr_addr_sel_o,
  output logic [1:0]            wb_mux_sel_o,
  output logic                  regfile_wr_en_o,
  output logic                  misaligned_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_e;

  state_e      r_state, w_state_nxt;
  logic        w_is_load, w_is_store, w_is_half, w_is_word, w_misal, w_mem_go, w_done;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;

  logic                  r_valid, r_branch, r_rf_we;
  logic [31:0]           r_ex, r_mem_data, r_next_pc;
  logic [4:0]            r_rd_addr;
  instr_addr_sel_state_e r_sel;
  logic [1:0]            r_wb_sel;

  assign w_is_load  = operation_i inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  assign w_is_store = operation_i inside {OP_SB, OP_SH, OP_SW};
  assign w_is_half  = operation_i inside {OP_LH, OP_LHU, OP_SH};
  assign w_is_word  = operation_i inside {OP_LW, OP_SW};

`ifdef KAMUS_MISALIGN_TRAP_EN
  assign w_misal = valid_i & ((w_is_half & ex_i[0]) | (w_is_word & |ex_i[1:0]));
`else
  assign w_misal = 1'b0;
`endif

  assign w_mem_go = valid_i & (w_is_load | w_is_store) & ~w_misal;

  // Upstream is stalled while the access is outstanding, so all *_i fields stay valid in REQ/WAIT_RSP
  assign dmem.req   = ~rst_i & (r_state == REQ | (r_state == IDLE & w_mem_go));
  assign dmem.we    = w_is_store & l1d_wr_en_i;
  assign dmem.addr  = {ex_i[31:2], 2'b00};
  assign dmem.be    = operation_i == OP_SB ? 4'b0001 << ex_i[1:0] :
                      operation_i == OP_SH ? 4'b0011 << {ex_i[1], 1'b0} : 4'hF;
  assign dmem.wdata = operation_i == OP_SB ? {4{rs2_data_i[7:0]}} :
                      operation_i == OP_SH ? {2{rs2_data_i[15:0]}} : rs2_data_i;

  assign w_byte = 8'(dmem.rdata >> {ex_i[1:0], 3'b000});
  assign w_half = 16'(dmem.rdata >> {ex_i[1], 4'b0000});
  assign w_ld   = operation_i == OP_LB  ? {{24{w_byte[7]}}, w_byte} :
                  operation_i == OP_LBU ? {24'b0, w_byte} :
                  operation_i == OP_LH  ? {{16{w_half[15]}}, w_half} :
                  operation_i == OP_LHU ? {16'b0, w_half} : dmem.rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_done      = valid_i & (~w_mem_go | (dmem.gnt & w_is_store));
        w_state_nxt = ~w_mem_go ? IDLE : ~dmem.gnt ? REQ : w_is_load ? WAIT_RSP : IDLE;
      end
      REQ: begin
        w_done      = dmem.gnt & w_is_store;
        w_state_nxt = ~dmem.gnt ? REQ : w_is_load ? WAIT_RSP : IDLE;
      end
      WAIT_RSP: begin
        w_done      = dmem.rvalid;
        w_state_nxt = dmem.rvalid ? IDLE : WAIT_RSP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign stall_o = ~rst_i & valid_i & (w_is_load | w_is_store) & ~w_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_valid    <= 1'b0;
      r_ex       <= '0;
      r_mem_data <= '0;
      r_rd_addr  <= '0;
      r_next_pc  <= '0;
      r_branch   <= 1'b0;
      r_sel      <= SEL_PC4;
      r_wb_sel   <= '0;
      r_rf_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_done;
      r_rf_we <= w_done & regfile_wr_en_i & ~w_is_store & ~w_misal;
      if (w_done) begin
        r_ex       <= ex_i;
        r_mem_data <= w_mem_go & w_is_load ? w_ld : 32'b0;
        r_rd_addr  <= rd_addr_i;
        r_next_pc  <= next_pc_i;
        r_branch   <= is_branch_taken_i;
        r_sel      <= instr_addr_sel_i;
        r_wb_sel   <= wb_mux_sel_i;
      end
    end
  end

`ifdef KAMUS_MISALIGN_TRAP_EN
  logic r_misal;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_misal <= 1'b0;
    else       r_misal <= w_done & w_misal;
  end
  assign misaligned_o = r_misal;
`else
  assign misaligned_o = 1'b0;
`endif

  assign valid_o           = r_valid;
  assign ex_o              = r_ex;
  assign mem_data_o        = r_mem_data;
  assign rd_addr_o         = r_rd_addr;
  assign next_pc_o         = r_next_pc;
  assign is_branch_taken_o = r_branch;
  assign instr_addr_sel_o  = r_sel;
  assign wb_mux_sel_o      = r_wb_sel;
  assign regfile_wr_en_o   = r_rf_we;
endmodule
